capture_dump_controller: RTL
============================

CAPTURE_DUMP_CONTROLLER -- requirements
Module: capture_dump_controller

Interface
REQ-001 Parameter: ADDR_BITS, 9, capture buffer address width; buffer depth is 2^ADDR_BITS words.
REQ-002 Parameter: WORD_BYTES, 16, capture word width in bytes; the data width is WORD_BYTES*8.
REQ-003 Port: clk  in  1  single clock for all logic.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: la_done  in  1  analyzer capture-complete flag, level.
REQ-006 Port: la_reset  out  1  one-cycle pulse that re-arms the analyzer.
REQ-007 Port: la_read_addr  out  ADDR_BITS  capture buffer read address.
REQ-008 Port: la_read_data  in  WORD_BYTES*8  capture word; valid 1 cycle after la_read_addr changes.
REQ-009 Port: tx_data  out  8  byte to the UART.
REQ-010 Port: tx_en  out  1  one-cycle byte strobe to the UART.
REQ-011 Port: tx_active  in  1  UART busy; rises 1 cycle after tx_en.
REQ-012 Port: abort  in  1  host request to cancel the dump.
REQ-013 Port: busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, HDR, LOAD, SEND, WAIT, REARM.
REQ-015 IDLE -> (HDR if CDC_HEADER_EN, else LOAD) on a cycle where la_done=1 and the registered previous la_done=0; entry sets la_read_addr=0 and byte index=0.
REQ-016 LOAD: one wait cycle; the next cycle latches la_read_data into an internal word register, then -> SEND.
REQ-017 SEND: asserts tx_en for exactly 1 cycle with tx_data = word byte[index], MSB byte first (index 0 = bits [WORD_BYTES*8-1 -: 8]), then -> WAIT.
REQ-018 WAIT: ignores tx_active on the first cycle, then waits for tx_active=0.
REQ-019 WAIT exit: index<WORD_BYTES-1 -> index+1, SEND; otherwise index=0 and, if addr<2^ADDR_BITS-1, addr+1 and LOAD; else REARM.
REQ-020 REARM: la_reset=1 for exactly 1 cycle, la_read_addr=0, -> IDLE.
REQ-021 Byte spacing: consecutive tx_en pulses are at least 2 cycles apart; tx_en never asserts while tx_active=1.
REQ-022 Abort: abort=1, or la_done=0, in any state except IDLE/REARM -> REARM next cycle; any in-flight UART byte completes untouched.
REQ-023 Simultaneous events: abort in the same cycle as the final WAIT exit -> REARM, with a single la_reset pulse.
REQ-024 la_read_addr is stable from LOAD entry until that word's last byte leaves SEND.
REQ-025 Arithmetic: address and index counters are unsigned, no wrap; terminal values are decoded explicitly.
REQ-026 Word count: a full dump emits 2^ADDR_BITS*WORD_BYTES data bytes (default 8192).

Reset
REQ-027 Asynchronous reset drives state=IDLE, tx_en=0, tx_data=0, la_reset=0, la_read_addr=0, busy=0, index=0, previous la_done=0.
REQ-028 Reset asserted mid-dump: no further tx_en or la_reset; the analyzer is not re-armed by this block.
REQ-029 A la_done already high at reset release does not start a dump; a fresh rising edge is required.

Configuration
REQ-030 Macro CDC_HEADER_EN defined: HDR sends 0x55, 0xAA, ADDR_BITS, WORD_BYTES using the same SEND/WAIT handshake, then -> LOAD; abort applies in HDR.
REQ-031 Macro CDC_HEADER_EN undefined: no HDR state, no header bytes; the first transmitted byte is word 0, byte 0.

Verification
REQ-032 ADDR_BITS=2, WORD_BYTES=2, buffer = 0x1122,0x3344,0x5566,0x7788, UART model busy 10 cycles -> bytes 11 22 33 44 55 66 77 88, then one la_reset pulse, busy=0.
REQ-033 Same setup with CDC_HEADER_EN -> 55 AA 02 02 followed by the same 8 bytes.
REQ-034 abort pulsed after the 3rd tx_en -> no 4th tx_en, la_reset pulses once within 2 cycles, IDLE.
REQ-035 la_done held high across reset release -> no tx_en; a later 0->1 edge starts the dump at addr 0.
REQ-036 tx_active stuck high 1000 cycles -> tx_en stays 0 and addr stays constant; on release, transmission resumes with the next byte.
REQ-037 Reset asserted mid-word -> all outputs 0 in the same cycle, no la_reset pulse.

Source files
------------

// File: rtl/capture_dump_controller.sv
// capture_dump_controller
//   Dumps a logic-analyzer capture buffer over a byte-wide UART. A rising
//   edge on la_done starts the dump. Each buffer word is read and sent MSB
//   byte first with a tx_en/tx_active handshake. After the last word, or on
//   abort or on la_done dropping, the analyzer is re-armed with a one-cycle
//   la_reset pulse.
//   Optional feature: define CDC_HEADER_EN to prefix the dump with the header
//   bytes 0x55, 0xAA, ADDR_BITS, WORD_BYTES.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   la_done        analyzer capture-complete level
//   la_reset       one-cycle re-arm pulse to the analyzer
//   la_read_addr   capture buffer read address
//   la_read_data   capture word, valid one cycle after la_read_addr changes
//   tx_data/tx_en  byte and one-cycle strobe to the UART
//   tx_active      UART busy flag
//   abort          host request to cancel the dump
//   busy           high whenever the controller is not idle
module capture_dump_controller #(
  parameter int ADDR_BITS  = 9,
  parameter int WORD_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    la_done,
  output logic                    la_reset,
  output logic [ADDR_BITS-1:0]    la_read_addr,
  input  logic [WORD_BYTES*8-1:0] la_read_data,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  input  logic                    tx_active,
  input  logic                    abort,
  output logic                    busy
);

  localparam int W     = WORD_BYTES * 8;
  localparam int IDX_W = $clog2(WORD_BYTES) + 2;
  localparam logic [IDX_W-1:0]     LAST_BYTE = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] REARM = 3'd5;
`ifdef CDC_HEADER_EN
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [IDX_W-1:0] LAST_HDR = IDX_W'(3);

  logic hdr_phase;

  function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): hdr_byte = 8'h55;
      IDX_W'(1): hdr_byte = 8'hAA;
      IDX_W'(2): hdr_byte = 8'(ADDR_BITS);
      default:   hdr_byte = 8'(WORD_BYTES);
    endcase
  endfunction
`endif

  logic [2:0]       state;
  logic [IDX_W-1:0] index;
  logic [W-1:0]     word;       // remaining bytes of the current word, next byte at the top
  logic             load_wait;  // second LOAD cycle: read data is valid
  logic             wait_first; // first WAIT cycle: tx_active not yet meaningful
  logic             la_done_q;
  logic             primed;     // la_done_q holds a real post-reset sample
  logic             start;
  logic             cancel;

  // primed blocks a la_done that was already high across reset release from
  // looking like a fresh rising edge on the first cycle.
  assign start  = la_done & ~la_done_q & primed;
  assign cancel = abort | ~la_done;

  always_comb busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      word         <= '0;
      load_wait    <= 1'b0;
      wait_first   <= 1'b0;
      la_done_q    <= 1'b0;
      primed       <= 1'b0;
      tx_en        <= 1'b0;
      tx_data      <= '0;
      la_reset     <= 1'b0;
      la_read_addr <= '0;
`ifdef CDC_HEADER_EN
      hdr_phase    <= 1'b0;
`endif
    end else begin
      la_done_q <= la_done;
      primed    <= 1'b1;
      tx_en     <= 1'b0;
      la_reset  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            la_read_addr <= '0;
            index        <= '0;
            load_wait    <= 1'b0;
`ifdef CDC_HEADER_EN
            hdr_phase    <= 1'b1;
            state        <= HDR;
`else
            state        <= LOAD;
`endif
          end
        end
        REARM: state <= IDLE;
        default: begin
          if (cancel) begin
            state        <= REARM;
            la_reset     <= 1'b1;
            la_read_addr <= '0;
            index        <= '0;
            load_wait    <= 1'b0;
`ifdef CDC_HEADER_EN
            hdr_phase    <= 1'b0;
`endif
          end else begin
            case (state)
`ifdef CDC_HEADER_EN
              HDR: begin
                tx_data <= hdr_byte(index);
                tx_en   <= 1'b1;
                state   <= SEND;
              end
`endif
              LOAD: begin
                if (!load_wait) begin
                  load_wait <= 1'b1;
                end else begin
                  // First byte comes straight off the bus; the rest are shifted out of word.
                  load_wait <= 1'b0;
                  word      <= la_read_data << 8;
                  tx_data   <= la_read_data[W-1 -: 8];
                  tx_en     <= 1'b1;
                  state     <= SEND;
                end
              end
              SEND: begin
                wait_first <= 1'b1;
                state      <= WAIT;
              end
              WAIT: begin
                if (wait_first) begin
                  wait_first <= 1'b0;
                end else if (!tx_active) begin
`ifdef CDC_HEADER_EN
                  if (hdr_phase) begin
                    if (index != LAST_HDR) begin
                      index <= index + 1'b1;
                      state <= HDR;
                    end else begin
                      index     <= '0;
                      hdr_phase <= 1'b0;
                      state     <= LOAD;
                    end
                  end else
`endif
                  if (index != LAST_BYTE) begin
                    index   <= index + 1'b1;
                    tx_data <= word[W-1 -: 8];
                    word    <= word << 8;
                    tx_en   <= 1'b1;
                    state   <= SEND;
                  end else begin
                    index <= '0;
                    if (la_read_addr != LAST_ADDR) begin
                      la_read_addr <= la_read_addr + 1'b1;
                      state        <= LOAD;
                    end else begin
                      la_read_addr <= '0;
                      la_reset     <= 1'b1;
                      state        <= REARM;
                    end
                  end
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
